// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the address-decode region type.
package dmem_pkg;

  localparam logic [3:0] GPIO_OFS     = 4'h0;
  localparam logic [3:0] MTIME_OFS    = 4'h4;
  localparam logic [3:0] MTIMECMP_OFS = 4'h8;
  localparam logic [3:0] STATUS_OFS   = 4'hC;

  localparam int ST_IRQ = 0;
  localparam int ST_ERR = 1;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO,
    REG_MTIME,
    REG_MTIMECMP,
    REG_STATUS,
    REG_NONE
  } region_t;

endpackage

// File: rtl/mmio_timer.sv
// Machine timer: free-running MTIME, MTIMECMP and a sticky compare interrupt.
// Only instantiated when DMEM_TIMER_EN is defined.
module mmio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtime_we,
  input  logic        mtimecmp_we,
  input  logic [31:0] wdata,
  input  logic        irq_clr,
  output logic [31:0] mtime,
  output logic [31:0] mtimecmp,
  output logic        irq
);

  // Counter increments every edge and wraps; a core write overrides the increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         mtime <= '0;
    else if (mtime_we) mtime <= wdata;
    else               mtime <= mtime + 32'd1;
  end

  // Compare register resets to all-ones so the interrupt stays quiet after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            mtimecmp <= '1;
    else if (mtimecmp_we) mtimecmp <= wdata;
  end

  // Sticky interrupt: a match on the current values sets it and beats a clear on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  irq <= 1'b0;
    else if (mtime == mtimecmp) irq <= 1'b1;
    else if (irq_clr)           irq <= 1'b0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the single-cycle RV32 core: word RAM plus an MMIO
// window (GPIO, machine timer, STATUS). Reads are combinational, writes land
// on the rising edge. Define DMEM_TIMER_EN to include the machine timer;
// without it the MTIME/MTIMECMP offsets are unmapped and timer_irq is 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  region_t        region;
  logic [AW-1:0]  word_idx;
  logic [31:0]    ram [DEPTH_WORDS];
  logic           err_sticky;
  logic           wr_illegal;
  logic           status_wr;
  logic [31:0]    mtime;
  logic [31:0]    mtimecmp;

  assign word_idx   = ALUResult[AW+1:2];
  assign wr_illegal = MemWrite && (region == REG_NONE);
  assign status_wr  = MemWrite && (region == REG_STATUS);

  // Address decode: aligned RAM words first, then the four MMIO registers
  always_comb begin
    region = REG_NONE;
    if (ALUResult[1:0] == 2'b00) begin
      if (ALUResult < RAM_BYTES) begin
        region = REG_RAM;
      end else if (ALUResult[31:4] == MMIO_BASE[31:4]) begin
        case (ALUResult[3:0])
          GPIO_OFS:     region = REG_GPIO;
`ifdef DMEM_TIMER_EN
          MTIME_OFS:    region = REG_MTIME;
          MTIMECMP_OFS: region = REG_MTIMECMP;
`endif
          STATUS_OFS:   region = REG_STATUS;
          default:      region = REG_NONE;
        endcase
      end
    end
  end

`ifdef DMEM_TIMER_EN
  mmio_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .mtime_we    (MemWrite && (region == REG_MTIME)),
    .mtimecmp_we (MemWrite && (region == REG_MTIMECMP)),
    .wdata       (WriteData),
    .irq_clr     (status_wr && WriteData[ST_IRQ]),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .irq         (timer_irq)
  );
`else
  assign mtime     = '0;
  assign mtimecmp  = '0;
  assign timer_irq = 1'b0;
`endif

  // RAM word write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (MemWrite && (region == REG_RAM)) ram[word_idx] <= WriteData;
  end

  // GPIO output register takes the low byte of a store
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                gpio_out <= '0;
    else if (MemWrite && (region == REG_GPIO)) gpio_out <= WriteData[7:0];
  end

  // Error flags: one-cycle pulse plus a sticky bit whose set beats a W1C clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      bus_err <= wr_illegal;
      if (wr_illegal)                       err_sticky <= 1'b1;
      else if (status_wr && WriteData[ST_ERR]) err_sticky <= 1'b0;
    end
  end

  // Combinational read mux; unmapped or misaligned addresses read as zero
  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM:      ReadData = ram[word_idx];
      REG_GPIO:     ReadData = {24'b0, gpio_out};
      REG_MTIME:    ReadData = mtime;
      REG_MTIMECMP: ReadData = mtimecmp;
      REG_STATUS: begin
        ReadData[ST_IRQ] = timer_irq;
        ReadData[ST_ERR] = err_sticky;
      end
      default:      ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of RAM/GPIO/STATUS/error
// vectors followed by hand-written timer and asynchronous-reset sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(1'b0, addr, 32'h0);
    #1;
    checkOutput(name, ReadData, expected);
  endtask

  task automatic addVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input logic [7:0] exp_gpio);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_gpio = exp_gpio;
    vecs.push_back(v);
  endtask

  initial begin
    addVec(1, 32'h20,      32'hDEAD_BEEF, 0,             0, 8'h00);
    addVec(0, 32'h20,      0,             32'hDEAD_BEEF, 0, 8'h00);
    addVec(1, 32'h24,      32'h1234_5678, 0,             0, 8'h00);
    addVec(0, 32'h24,      0,             32'h1234_5678, 0, 8'h00);
    addVec(1, 32'hFC,      32'hCAFE_F00D, 0,             0, 8'h00);
    addVec(1, 32'h00,      32'h1111_1111, 0,             0, 8'h00);
    addVec(0, 32'hFC,      0,             32'hCAFE_F00D, 0, 8'h00);
    addVec(0, 32'h00,      0,             32'h1111_1111, 0, 8'h00);
    addVec(0, 32'h20,      0,             32'hDEAD_BEEF, 0, 8'h00);
    addVec(1, 32'h22,      32'h0,         0,             1, 8'h00);
    addVec(0, BASE + 'hC,  0,             32'h2,         0, 8'h00);
    addVec(0, 32'h20,      0,             32'hDEAD_BEEF, 0, 8'h00);
    addVec(1, BASE,        32'hFFFF_FFA5, 0,             0, 8'hA5);
    addVec(0, BASE,        0,             32'hA5,        0, 8'hA5);
    addVec(1, BASE + 'h2,  32'h0,         0,             1, 8'hA5);
    addVec(0, BASE + 'h2,  0,             32'h0,         0, 8'hA5);
    addVec(1, 32'h100,     32'h5,         0,             1, 8'hA5);
    addVec(1, BASE + 'h10, 32'h5,         0,             1, 8'hA5);
    addVec(0, 32'h100,     0,             32'h0,         0, 8'hA5);
    addVec(0, BASE + 'h10, 0,             32'h0,         0, 8'hA5);
    addVec(1, BASE + 'hC,  32'h0,         0,             0, 8'hA5);
    addVec(0, BASE + 'hC,  0,             32'h2,         0, 8'hA5);
    addVec(1, BASE + 'hC,  32'h2,         0,             0, 8'hA5);
    addVec(0, BASE + 'hC,  0,             32'h0,         0, 8'hA5);
    addVec(1, BASE + 'hE,  32'h2,         0,             1, 8'hA5);
    addVec(0, BASE + 'hC,  0,             32'h2,         0, 8'hA5);
    addVec(1, BASE + 'hC,  32'h1,         0,             0, 8'hA5);
    addVec(0, BASE + 'hC,  0,             32'h2,         0, 8'hA5);
    addVec(1, BASE + 'hC,  32'h3,         0,             0, 8'hA5);
    addVec(0, BASE + 'hC,  0,             32'h0,         0, 8'hA5);

    // Reset phase
    reset = 1'b1;
    applyStimulus(1'b0, BASE, 32'h0);
    step();
    step();
    checkOutput("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
    checkOutput("rst_timer_irq", {31'b0, timer_irq}, 32'h0);
    checkOutput("rst_bus_err", {31'b0, bus_err}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
`ifdef DMEM_TIMER_EN
    readCheck("mtime_after_5", BASE + 'h4, 32'd5);
    readCheck("mtimecmp_reset", BASE + 'h8, 32'hFFFF_FFFF);
`else
    readCheck("mtime_unmapped", BASE + 'h4, 32'h0);
    readCheck("mtimecmp_unmapped", BASE + 'h8, 32'h0);
`endif
    readCheck("gpio_reset_read", BASE, 32'h0);
    step();
    readCheck("status_reset_read", BASE + 'hC, 32'h0);
    checkOutput("irq_after_reset", {31'b0, timer_irq}, 32'h0);
    step();

    // Table-driven RAM/GPIO/STATUS/error vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (!vecs[i].we) checkOutput($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      step();
      checkOutput($sformatf("vec%0d_bus_err", i), {31'b0, bus_err}, {31'b0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_gpio", i), {24'b0, gpio_out}, {24'b0, vecs[i].exp_gpio});
    end

`ifdef DMEM_TIMER_EN
    // Compare match raises the sticky interrupt one cycle after MTIME reads MTIMECMP
    applyStimulus(1'b1, BASE + 'h8, 32'd10);
    step();
    applyStimulus(1'b1, BASE + 'h4, 32'd0);
    step();
    readCheck("mtime_written_0", BASE + 'h4, 32'd0);
    for (int i = 0; i < 10; i++) step();
    readCheck("mtime_at_cmp", BASE + 'h4, 32'd10);
    checkOutput("irq_before_match_edge", {31'b0, timer_irq}, 32'h0);
    step();
    checkOutput("irq_after_match_edge", {31'b0, timer_irq}, 32'h1);
    applyStimulus(1'b1, BASE + 'h4, 32'hFFFF_FFFE);
    step();
    readCheck("mtime_wrap_fe", BASE + 'h4, 32'hFFFF_FFFE);
    step();
    readCheck("mtime_wrap_ff", BASE + 'h4, 32'hFFFF_FFFF);
    step();
    readCheck("mtime_wrap_00", BASE + 'h4, 32'h0);
    checkOutput("irq_held_over_wrap", {31'b0, timer_irq}, 32'h1);
    applyStimulus(1'b1, BASE + 'hC, 32'h1);
    step();
    checkOutput("irq_w1c_clear", {31'b0, timer_irq}, 32'h0);
    readCheck("status_after_clear", BASE + 'hC, 32'h0);
    step();

    // W1C on the same edge as a match: the set wins
    applyStimulus(1'b1, BASE + 'h8, 32'd100);
    step();
    applyStimulus(1'b1, BASE + 'h4, 32'd99);
    step();
    applyStimulus(1'b0, BASE + 'h4, 32'h0);
    step();
    readCheck("mtime_at_100", BASE + 'h4, 32'd100);
    checkOutput("irq_before_collision", {31'b0, timer_irq}, 32'h0);
    applyStimulus(1'b1, BASE + 'hC, 32'h1);
    step();
    checkOutput("irq_set_beats_clear", {31'b0, timer_irq}, 32'h1);
    readCheck("status_irq_bit", BASE + 'hC, 32'h1);
    step();
`else
    // Timer offsets are unmapped: writes are illegal and timer_irq never rises
    applyStimulus(1'b1, BASE + 'h8, 32'd10);
    step();
    checkOutput("mtimecmp_write_err", {31'b0, bus_err}, 32'h1);
    applyStimulus(1'b1, BASE + 'h4, 32'd0);
    step();
    checkOutput("mtime_write_err", {31'b0, bus_err}, 32'h1);
    readCheck("status_err_only", BASE + 'hC, 32'h2);
    applyStimulus(1'b1, BASE + 'hC, 32'h1);
    step();
    checkOutput("bus_err_drops", {31'b0, bus_err}, 32'h0);
    readCheck("status_bit0_w1c_noeffect", BASE + 'hC, 32'h2);
    checkOutput("irq_tied_low", {31'b0, timer_irq}, 32'h0);
    step();
`endif

    // Asynchronous reset between edges while outputs are active
    applyStimulus(1'b1, 32'h22, 32'h0);
    step();
    checkOutput("bus_err_before_reset", {31'b0, bus_err}, 32'h1);
    applyStimulus(1'b0, BASE, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_gpio", {24'b0, gpio_out}, 32'h0);
    checkOutput("async_rst_irq", {31'b0, timer_irq}, 32'h0);
    checkOutput("async_rst_bus_err", {31'b0, bus_err}, 32'h0);
    step();
    readCheck("async_rst_status", BASE + 'hC, 32'h0);
`ifdef DMEM_TIMER_EN
    readCheck("async_rst_mtimecmp", BASE + 'h8, 32'hFFFF_FFFF);
    readCheck("async_rst_mtime", BASE + 'h4, 32'h0);
`endif
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
